item_select_fsm: RTL and testbench
==================================

# item_select_fsm

Item-selection controller that drives the 3-bit item code consumed by the six-digit item-name display decoder. It turns synchronized pushbutton levels into single-step and auto-repeat moves through the six legal item codes, skipping the two unused codes and wrapping at both ends. A lock input freezes the selection. Sits between the input synchronizers and the display decoder.

## Interface
- HOLD_CYCLES, default 25_000_000: cycles a button is held after its first step before auto-repeat starts (≥2).
- REPEAT_CYCLES, default 5_000_000: cycles between auto-repeat steps (≥2).
- CNT_W, default 32: width of the hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES).
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- next  in  1  step-forward button level, active-high, already synchronized to clk.
- prev  in  1  step-backward button level, active-high, already synchronized.
- lock  in  1  lock-toggle button level, active-high, already synchronized.
- bcd  out  3  registered item code: 000 pen, 001 glasses, 011 bottle, 100 cup, 101 spoon, 110 apple.
- locked  out  1  registered; 1 while selection is frozen.
- changed  out  1  registered one-cycle pulse, 1 in the cycle after bcd took a new value.

## Operation
- Legal forward order: 000→001→011→100→101→110→000 (wrap). Backward is the exact reverse (000→110). Codes 010 and 111 are never output.
- Recovery: if the bcd register ever holds 010 or 111, it is forced to 000 on the next edge (changed pulses).
- Edge detect: next_q, prev_q, lock_q register previous levels; rise = level & ~level_q.
- States: IDLE, HOLD_FWD, HOLD_BWD, REPEAT_FWD, REPEAT_BWD.
- IDLE: next rise with prev=0 → step forward, counter←0, go HOLD_FWD. prev rise with next=0 → step backward, go HOLD_BWD. Both high → no step, stay IDLE.
- HOLD_x: counter increments each cycle while the button stays high and the other is low. When counter = HOLD_CYCLES-1 → step, counter←0, go REPEAT_x.
- REPEAT_x: same, with REPEAT_CYCLES-1 as the threshold; step and counter←0, remain in REPEAT_x.
- Release of the active button, or the other button going high, in any HOLD/REPEAT state → IDLE, counter←0, no step that cycle. A new rise is required to move again.
- Lock: lock rise toggles locked. The toggle has priority: a step that would occur in the same cycle is suppressed, FSM→IDLE, counter←0.
- While locked=1: next/prev ignored, FSM held in IDLE, counter held at 0; bcd constant.
- changed = 1 exactly in cycles following an edge where bcd was written with a different value.

## Timing
- Reset (async, immediate): bcd=000, locked=0, changed=0, FSM=IDLE, counter=0, next_q=prev_q=lock_q=0.
- Button held high through reset release: counts as a rise on the first clock edge after release.
- Step latency: rise sampled at edge k → bcd new value visible after edge k; changed=1 for the cycle after edge k.
- Held button with first step at edge k: repeats at edges k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2·REPEAT_CYCLES, …
- Lock latency: lock rise at edge k → locked toggles after edge k.
- Reset asserted mid-hold or mid-repeat: everything returns to reset values at once; no step is pending after release.

## Test plan
- Reset then 7 single next pulses (1 cycle high, 3 low) → bcd 001,011,100,101,110,000,001; changed pulses 7 times, never 010/111.
- From 000, one prev pulse → bcd=110; second pulse → 101.
- HOLD_CYCLES=4, REPEAT_CYCLES=2, hold next 10 cycles from 000 → steps at edges 0,4,6,8: bcd 001,011,100,101; release → no further change.
- Lock pulse → locked=1; next/prev pulses and holds → bcd unchanged, changed=0; second lock pulse → locked=0, next pulse steps normally.
- next and prev rising together → no change; during hold of next, assert prev → repeat stops, FSM IDLE, bcd frozen.
- Reset asserted during REPEAT_FWD → immediately bcd=000, locked=0, changed=0; force bcd reg to 111 → bcd=000 next edge with changed=1.

Source files
------------

// File: rtl/item_select_if.sv
// Button levels into the item-selection controller and the registered item code,
// lock flag and change pulse it presents to the display decoder.
`timescale 1ns/1ps
interface item_select_if;
    logic       next;
    logic       prev;
    logic       lock;
    logic [2:0] bcd;
    logic       locked;
    logic       changed;

    modport master (
        output next, prev, lock,
        input  bcd, locked, changed
    );

    modport slave (
        input  next, prev, lock,
        output bcd, locked, changed
    );
endinterface

// File: rtl/item_select_fsm.sv
// Item-selection controller: single-step and auto-repeat moves through the six legal
// item codes with wrap in both directions, plus a lock toggle that freezes selection.
`timescale 1ns/1ps
module item_select_fsm #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_W         = 32
) (
    input  logic          clk,
    input  logic          reset,
    item_select_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOLD_FWD   = 3'd1,
        HOLD_BWD   = 3'd2,
        REPEAT_FWD = 3'd3,
        REPEAT_BWD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bcd_reg, bcd_next;
    logic             locked_reg, locked_next;
    logic             changed_reg, changed_next;
    logic             next_q, prev_q, lock_q;
    logic             next_rise, prev_rise, lock_rise;
    logic             step_fwd, step_bwd;
    logic [CNT_W-1:0] limit;

    // Legal ring: 000 -> 001 -> 011 -> 100 -> 101 -> 110 -> 000
    function automatic logic [2:0] fwd_code(input logic [2:0] code);
        case (code)
            3'b000:  fwd_code = 3'b001;
            3'b001:  fwd_code = 3'b011;
            3'b011:  fwd_code = 3'b100;
            3'b100:  fwd_code = 3'b101;
            3'b101:  fwd_code = 3'b110;
            default: fwd_code = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] bwd_code(input logic [2:0] code);
        case (code)
            3'b000:  bwd_code = 3'b110;
            3'b110:  bwd_code = 3'b101;
            3'b101:  bwd_code = 3'b100;
            3'b100:  bwd_code = 3'b011;
            3'b011:  bwd_code = 3'b001;
            default: bwd_code = 3'b000;
        endcase
    endfunction

    assign next_rise = bus.next & ~next_q;
    assign prev_rise = bus.prev & ~prev_q;
    assign lock_rise = bus.lock & ~lock_q;

    assign limit = (state_reg == HOLD_FWD || state_reg == HOLD_BWD) ? HOLD_LAST : REPEAT_LAST;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bcd_reg     <= 3'b000;
            locked_reg  <= 1'b0;
            changed_reg <= 1'b0;
            next_q      <= 1'b0;
            prev_q      <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            locked_reg  <= locked_next;
            changed_reg <= changed_next;
            next_q      <= bus.next;
            prev_q      <= bus.prev;
            lock_q      <= bus.lock;
        end
    end

    // Next-state logic; a lock toggle overrides any step in the same cycle
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        locked_next = locked_reg;
        step_fwd    = 1'b0;
        step_bwd    = 1'b0;
        if (lock_rise) begin
            locked_next = ~locked_reg;
            state_next  = IDLE;
            cnt_next    = '0;
        end else if (locked_reg) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (next_rise && !bus.prev) begin
                        step_fwd   = 1'b1;
                        state_next = HOLD_FWD;
                    end else if (prev_rise && !bus.next) begin
                        step_bwd   = 1'b1;
                        state_next = HOLD_BWD;
                    end
                end
                HOLD_FWD, REPEAT_FWD: begin
                    if (bus.next && !bus.prev) begin
                        if (cnt_reg == limit) begin
                            step_fwd   = 1'b1;
                            cnt_next   = '0;
                            state_next = REPEAT_FWD;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HOLD_BWD, REPEAT_BWD: begin
                    if (bus.prev && !bus.next) begin
                        if (cnt_reg == limit) begin
                            step_bwd   = 1'b1;
                            cnt_next   = '0;
                            state_next = REPEAT_BWD;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output logic; an illegal code held in the register is pulled back to 000
    always_comb begin
        bcd_next = bcd_reg;
        if (bcd_reg == 3'b010 || bcd_reg == 3'b111) begin
            bcd_next = 3'b000;
        end else if (step_fwd) begin
            bcd_next = fwd_code(bcd_reg);
        end else if (step_bwd) begin
            bcd_next = bwd_code(bcd_reg);
        end
        changed_next = (bcd_next != bcd_reg);
    end

    assign bus.bcd     = bcd_reg;
    assign bus.locked  = locked_reg;
    assign bus.changed = changed_reg;

endmodule

// File: tb/tb_item_select_fsm.sv
// Scoreboard bench for item_select_fsm: stimulus pushes expected codes, a negedge
// monitor pops one per change pulse; direct checks cover reset, lock and timing.
`timescale 1ns/1ps
module tb_item_select_fsm;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_v;

    item_select_if bus();

    item_select_fsm #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // which: 0 next, 1 prev, 2 lock; high for hi cycles then 3 low
    task automatic press(input int which, input int hi);
        case (which)
            0: bus.next = 1'b1;
            1: bus.prev = 1'b1;
            default: bus.lock = 1'b1;
        endcase
        repeat (hi) @(negedge clk);
        bus.next = 1'b0;
        bus.prev = 1'b0;
        bus.lock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every change pulse must match the oldest expected code
    always @(negedge clk) begin
        if (!reset && bus.changed) begin
            n_cmp++;
            if (bus.bcd == 3'b010 || bus.bcd == 3'b111) begin
                n_err++;
                $display("FAIL illegal_code: bcd=%b, required a legal code", bus.bcd);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change: bcd=%b, required no change", bus.bcd);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.bcd !== exp_v) begin
                    n_err++;
                    $display("FAIL scoreboard: bcd=%b, required %b", bus.bcd, exp_v);
                end else begin
                    $display("ok   scoreboard: bcd=%b", bus.bcd);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq_fwd [7];
        seq_fwd = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b001};

        reset    = 1'b1;
        bus.next = 1'b0;
        bus.prev = 1'b0;
        bus.lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_bcd", bus.bcd, 3'b000);
        chk("reset_locked", bus.locked, 1'b0);
        chk("reset_changed", bus.changed, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Seven forward steps including the 110 -> 000 wrap
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(seq_fwd[i]);
            press(0, 1);
        end

        // Backward through the wrap: 001 -> 000 -> 110 -> 101
        exp_q.push_back(3'b000); press(1, 1);
        exp_q.push_back(3'b110); press(1, 1);
        exp_q.push_back(3'b101); press(1, 1);

        // Auto-repeat timing from 000: steps at edges 0,4,6,8
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
        bus.next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_timing", bus.changed, (i == 0 || i == 4 || i == 6 || i == 8));
        end
        bus.next = 1'b0;
        repeat (6) @(negedge clk);
        chk("after_release_bcd", bus.bcd, 3'b101);

        // Locked: buttons ignored
        press(2, 1);
        chk("lock_on", bus.locked, 1'b1);
        press(0, 1);
        press(1, 1);
        press(0, 8);
        chk("locked_bcd", bus.bcd, 3'b101);
        press(2, 1);
        chk("lock_off", bus.locked, 1'b0);
        exp_q.push_back(3'b110);
        press(0, 1);

        // Lock rise and next rise together: toggle wins, no step
        bus.next = 1'b1;
        bus.lock = 1'b1;
        @(negedge clk);
        bus.next = 1'b0;
        bus.lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("lock_prio_locked", bus.locked, 1'b1);
        chk("lock_prio_bcd", bus.bcd, 3'b110);
        press(2, 1);
        chk("unlock_again", bus.locked, 1'b0);

        // next and prev rising together: no step
        bus.next = 1'b1;
        bus.prev = 1'b1;
        repeat (3) @(negedge clk);
        bus.next = 1'b0;
        bus.prev = 1'b0;
        repeat (3) @(negedge clk);
        chk("both_rise_bcd", bus.bcd, 3'b110);

        // Hold next, then assert prev: repeat stops
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        bus.next = 1'b1;
        repeat (5) @(negedge clk);
        bus.prev = 1'b1;
        repeat (8) @(negedge clk);
        bus.next = 1'b0;
        bus.prev = 1'b0;
        repeat (3) @(negedge clk);
        chk("other_button_bcd", bus.bcd, 3'b001);

        // Reset in REPEAT_FWD, just after a step
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b100);
        bus.next = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrun_reset_bcd", bus.bcd, 3'b000);
        chk("midrun_reset_locked", bus.locked, 1'b0);
        chk("midrun_reset_changed", bus.changed, 1'b0);
        bus.next = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_reset_bcd", bus.bcd, 3'b000);

        // Illegal code in the register is recovered to 000
        exp_q.push_back(3'b000);
        force dut.bcd_reg = 3'b111;
        #1;
        release dut.bcd_reg;
        repeat (3) @(negedge clk);
        chk("recover_bcd", bus.bcd, 3'b000);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
